// File: rtl/fetch_unit.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Keeps one imem read in flight, buffers a word that arrives during a stall, and drops wrong-path fetches on redirect.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_d,
    input  logic        flush_d,
    input  logic        pc_src_d,
    input  logic [31:0] pc_branch_d,
    input  logic        jump_d,
    input  logic [31:0] pc_jump_d,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr_d,
    output logic [31:0] pc_plus_4_d,
    output logic        valid_d,
    output logic [1:0]  fsm_state
);

    // Handshake: imem_req rises with a new imem_addr, both stay put until the
    // single-cycle imem_valid pulse, and req drops for at least one cycle before
    // the next address is presented.
    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam logic [31:0] PC_INIT = RESET_PC & 32'hFFFF_FFFC;

    state_t      state;
    logic [31:0] pc_f;
    logic [31:0] skid;
    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_seq;

    assign redirect  = valid_d & ~stall_d & (jump_d | pc_src_d);
    assign target    = (jump_d ? pc_jump_d : pc_branch_d) & 32'hFFFF_FFFC;
    assign pc_seq    = pc_f + 32'd4;
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ISSUE;
            pc_f        <= PC_INIT;
            skid        <= '0;
            imem_req    <= 1'b0;
            imem_addr   <= PC_INIT;
            instr_d     <= '0;
            pc_plus_4_d <= '0;
            valid_d     <= 1'b0;
        end else begin
            // IF/ID defaults to a bubble; a delivery below overrides it.
            if (flush_d || !stall_d) begin
                instr_d <= '0;
                valid_d <= 1'b0;
            end

            case (state)
                ISSUE: begin
                    imem_req  <= 1'b1;
                    imem_addr <= redirect ? target : pc_f;
                    if (redirect) begin
                        pc_f <= target;
                    end
                    state <= WAIT;
                end

                WAIT: begin
                    if (imem_valid) begin
                        imem_req <= 1'b0;
                        state    <= ISSUE;
                        if (redirect) begin
                            pc_f <= target;
                        end else if (flush_d || stall_d) begin
                            skid  <= imem_rdata;
                            state <= HOLD;
                        end else begin
                            instr_d     <= imem_rdata;
                            pc_plus_4_d <= pc_seq;
                            valid_d     <= 1'b1;
                            pc_f        <= pc_seq;
                        end
                    end else if (redirect) begin
                        // The request in flight is wrong-path; let it finish and discard it.
                        pc_f  <= target;
                        state <= DRAIN;
                    end
                end

                HOLD: begin
                    if (redirect) begin
                        pc_f  <= target;
                        skid  <= '0;
                        state <= ISSUE;
                    end else if (!stall_d && !flush_d) begin
                        instr_d     <= skid;
                        pc_plus_4_d <= pc_seq;
                        valid_d     <= 1'b1;
                        pc_f        <= pc_seq;
                        state       <= ISSUE;
                    end
                end

                DRAIN: begin
                    if (imem_valid) begin
                        imem_req <= 1'b0;
                        state    <= ISSUE;
                    end
                end

                default: state <= ISSUE;
            endcase
        end
    end

endmodule
